// File: rtl/divcnt_pkg.sv
// Shared types and register map for the divider-chain interval timer.
package divcnt_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } divcnt_state_e;

  // Register addresses
  localparam logic [1:0] A_LIMIT = 2'd0;
  localparam logic [1:0] A_CTRL  = 2'd1;
  localparam logic [1:0] A_COUNT = 2'd2;
  localparam logic [1:0] A_STAT  = 2'd3;

  // CTRL register bit positions
  localparam int unsigned CTRL_GO       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQEN    = 2;
  localparam int unsigned CTRL_PS_LSB   = 4;

endpackage

// File: rtl/divcnt_chain.sv
// Synchronous toggle-cell divider chain: each cell toggles when CE is high and
// every lower cell is 1. Active-low synchronous clear overrides counting.
module divcnt_chain #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             cll_ni,
  input  logic             ce_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] carry;

  // Carry-enable per cell, formed from the cell outputs directly so the
  // chain has no combinational self-reference.
  assign carry[0] = ce_i;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign carry[i] = ce_i & (&q_q[i-1:0]);
  end

  // Toggle or clear each cell.
  always_comb begin
    q_d = q_q;
    if (!cll_ni) q_d = '0;
    else         q_d = q_q ^ carry;
  end

  // Cell state register.
  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/divcnt_timer_ctrl.sv
// CPU-programmable interval timer sequencing a toggle-cell divider chain:
// prescaler, terminal-count compare, one-shot/periodic modes, sticky IRQ.
module divcnt_timer_ctrl
  import divcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PS_W  = 4
) (
  input  logic             MasterClock,
  input  logic             RESET,
  input  logic             CLKEN,
  input  logic             WR,
  input  logic [1:0]       ADDR,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             TC,
  output logic             IRQ,
  input  logic             IACK,
  output logic             RUNNING
);

  divcnt_state_e    state_q, state_d;
  logic [WIDTH-1:0] limit_sh_q, limit_sh_d;
  logic [WIDTH-1:0] limit_act_q, limit_act_d;
  logic             go_q, go_d, periodic_q, periodic_d, irqen_q, irqen_d;
  logic [PS_W-1:0]  ps_q, ps_d, psc_q, psc_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] count;
  logic             wr_limit, wr_ctrl, wr_stat, tick, wrap, cll_n;

  // Bus decode, tick generation and chain control.
  always_comb begin
    wr_limit = WR && (ADDR == A_LIMIT);
    wr_ctrl  = WR && (ADDR == A_CTRL);
    wr_stat  = WR && (ADDR == A_STAT);
    tick     = (state_q == StRun) && CLKEN && (psc_q == ps_q);
    wrap     = tick && (count == limit_act_q);
    // RESET folded into the clear so the count returns to 0 with everything else
    cll_n    = !(RESET || (state_q == StIdle) || wrap);
    TC       = wrap && !RESET;
  end

  divcnt_chain #(
    .WIDTH (WIDTH)
  ) u_chain (
    .clk_i  (MasterClock),
    .cll_ni (cll_n),
    .ce_i   (tick),
    .q_o    (count)
  );

  // Next-state: registers, prescaler, FSM and interrupt.
  always_comb begin
    state_d     = state_q;
    limit_sh_d  = limit_sh_q;
    limit_act_d = limit_act_q;
    go_d        = go_q;
    periodic_d  = periodic_q;
    irqen_d     = irqen_q;
    ps_d        = ps_q;
    psc_d       = psc_q;
    irq_d       = irq_q;

    if (wr_limit) limit_sh_d = DIN;
    if (wr_ctrl) begin
      go_d       = DIN[CTRL_GO];
      periodic_d = DIN[CTRL_PERIODIC];
      irqen_d    = DIN[CTRL_IRQEN];
      ps_d       = DIN[CTRL_PS_LSB +: PS_W];
    end

    // Prescaler idles at 0 outside RUN, so every entry into RUN starts fresh.
    if (state_q != StRun) psc_d = '0;
    else if (tick)        psc_d = '0;
    else if (CLKEN)       psc_d = psc_q + PS_W'(1);

    unique case (state_q)
      StIdle: begin
        if (wr_ctrl && DIN[CTRL_GO]) begin
          state_d     = StRun;
          limit_act_d = limit_sh_q;
        end
      end
      StRun: begin
        if (wr_ctrl && !DIN[CTRL_GO]) begin
          state_d = StIdle;
        end else if (wrap) begin
          if (periodic_q) begin
            limit_act_d = limit_sh_q;
          end else begin
            state_d = StDone;
            go_d    = 1'b0;
          end
        end
      end
      StDone: begin
        if (wr_ctrl) begin
          if (DIN[CTRL_GO]) begin
            state_d     = StRun;
            limit_act_d = limit_sh_q;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Set has priority over acknowledge.
    if (wrap && irqen_q)      irq_d = 1'b1;
    else if (IACK || wr_stat) irq_d = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      state_q     <= StIdle;
      limit_sh_q  <= '1;
      limit_act_q <= '1;
      go_q        <= 1'b0;
      periodic_q  <= 1'b0;
      irqen_q     <= 1'b0;
      ps_q        <= '0;
      psc_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      limit_sh_q  <= limit_sh_d;
      limit_act_q <= limit_act_d;
      go_q        <= go_d;
      periodic_q  <= periodic_d;
      irqen_q     <= irqen_d;
      ps_q        <= ps_d;
      psc_q       <= psc_d;
      irq_q       <= irq_d;
    end
  end

  // Read mux, combinational from ADDR.
  always_comb begin
    DOUT = '0;
    case (ADDR)
      A_LIMIT: DOUT = limit_sh_q;
      A_CTRL: begin
        DOUT[CTRL_GO]               = go_q;
        DOUT[CTRL_PERIODIC]         = periodic_q;
        DOUT[CTRL_IRQEN]            = irqen_q;
        DOUT[CTRL_PS_LSB +: PS_W]   = ps_q;
      end
      A_COUNT: DOUT = count;
      default: DOUT[2:0] = {state_q == StDone, irq_q, state_q == StRun};
    endcase
  end

  assign IRQ     = irq_q;
  assign RUNNING = (state_q == StRun);

endmodule

// File: tb/tb_divcnt_timer_ctrl.sv
// Directed bench for divcnt_timer_ctrl: a per-cycle vector table for reset
// and the basic periodic run, then hand-written multi-cycle corner cases.
module tb_divcnt_timer_ctrl;
  import divcnt_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clken, wr, iack;
  logic [1:0]  addr;
  logic [15:0] din, dout;
  logic        tc, irq, running;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic        exp_tc;
    logic        exp_irq;
    logic        exp_run;
  } vec_t;

  vec_t vq[$];

  divcnt_timer_ctrl #(
    .WIDTH (16),
    .PS_W  (4)
  ) dut (
    .MasterClock (clk),
    .RESET       (rst),
    .CLKEN       (clken),
    .WR          (wr),
    .ADDR        (addr),
    .DIN         (din),
    .DOUT        (dout),
    .TC          (tc),
    .IRQ         (irq),
    .IACK        (iack),
    .RUNNING     (running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    wr = 1'b1;
    addr = a;
    din = d;
    step();
    wr = 1'b0;
    din = '0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    chk(name, 32'(dout), 32'(exp));
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] a, input logic [15:0] d,
                              input logic [15:0] ed, input logic et, input logic ei,
                              input logic er);
    vec_t v;
    v.wr = w; v.addr = a; v.din = d;
    v.exp_dout = ed; v.exp_tc = et; v.exp_irq = ei; v.exp_run = er;
    return v;
  endfunction

  int highs, tc_n, tc_at;
  logic [15:0] exp_cnt4 [12] = '{0, 1, 2, 3, 4, 5, 0, 1, 0, 1, 0, 1};
  logic        iack5 [7] = '{0, 0, 0, 1, 1, 0, 0};
  logic        wst5  [7] = '{0, 0, 0, 0, 0, 1, 0};
  logic        tc5   [7] = '{0, 1, 0, 1, 0, 1, 0};
  logic        irq5  [7] = '{0, 0, 1, 1, 1, 0, 1};

  initial begin
    rst = 1'b1; clken = 1'b0; wr = 1'b0; iack = 1'b0; addr = '0; din = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset readback, then LIMIT=3 periodic IRQEN PS=0 with CLKEN constant.
    vq.push_back(mk(0, A_LIMIT, 16'h0,    16'hFFFF, 0, 0, 0));
    vq.push_back(mk(0, A_CTRL,  16'h0,    16'h0000, 0, 0, 0));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0000, 0, 0, 0));
    vq.push_back(mk(0, A_STAT,  16'h0,    16'h0000, 0, 0, 0));
    vq.push_back(mk(1, A_LIMIT, 16'h3,    16'hFFFF, 0, 0, 0));
    vq.push_back(mk(1, A_CTRL,  16'h7,    16'h0000, 0, 0, 0));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0000, 0, 0, 1));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0001, 0, 0, 1));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0002, 0, 0, 1));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0003, 1, 0, 1));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0000, 0, 1, 1));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0001, 0, 1, 1));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0002, 0, 1, 1));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0003, 1, 1, 1));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0000, 0, 1, 1));
    vq.push_back(mk(1, A_STAT,  16'h0,    16'h0003, 0, 1, 1));
    vq.push_back(mk(1, A_CTRL,  16'h0,    16'h0007, 0, 0, 1));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0003, 0, 0, 0));
    vq.push_back(mk(0, A_COUNT, 16'h0,    16'h0000, 0, 0, 0));

    clken = 1'b1;
    foreach (vq[i]) begin
      wr = vq[i].wr; addr = vq[i].addr; din = vq[i].din;
      #1;
      chk($sformatf("v%0d dout", i), 32'(dout), 32'(vq[i].exp_dout));
      chk($sformatf("v%0d tc", i), 32'(tc), 32'(vq[i].exp_tc));
      chk($sformatf("v%0d irq", i), 32'(irq), 32'(vq[i].exp_irq));
      chk($sformatf("v%0d running", i), 32'(running), 32'(vq[i].exp_run));
      step();
    end
    wr = 1'b0;

    // One-shot LIMIT=2 PS=3, CLKEN toggling: single TC on the 12th high cycle.
    clken = 1'b0;
    wr_reg(A_LIMIT, 16'h2);
    wr_reg(A_CTRL, 16'h31);
    addr = A_COUNT; highs = 0; tc_n = 0; tc_at = -1;
    for (int i = 0; i < 40; i++) begin
      clken = (i % 2 == 0);
      #1;
      if (clken) highs++;
      if (tc) begin tc_n++; tc_at = highs; end
      step();
    end
    chk("oneshot tc count", 32'(tc_n), 32'd1);
    chk("oneshot tc position", 32'(tc_at), 32'd12);
    #1;
    chk("oneshot running", 32'(running), 32'd0);
    rd_chk("oneshot stat", A_STAT, 16'h0004);
    rd_chk("oneshot ctrl", A_CTRL, 16'h0030);
    rd_chk("oneshot count", A_COUNT, 16'h0000);

    // Periodic LIMIT=5, LIMIT=1 written at count 2 takes effect after the wrap.
    clken = 1'b1;
    wr_reg(A_LIMIT, 16'h5);
    wr_reg(A_CTRL, 16'h3);
    for (int i = 0; i < 12; i++) begin
      wr = (i == 2); addr = (i == 2) ? A_LIMIT : A_COUNT; din = (i == 2) ? 16'h1 : 16'h0;
      #1;
      chk($sformatf("shadow c%0d tc", i), 32'(tc), 32'(i == 5 || i == 7 || i == 9 || i == 11));
      if (i != 2) chk($sformatf("shadow c%0d count", i), 32'(dout), 32'(exp_cnt4[i]));
      step();
    end
    wr = 1'b0;
    wr_reg(A_CTRL, 16'h0);
    step();
    rd_chk("stop count", A_COUNT, 16'h0000);

    // IRQ set/clear collisions with LIMIT=1: set always wins.
    wr_reg(A_LIMIT, 16'h1);
    wr_reg(A_CTRL, 16'h7);
    for (int i = 0; i < 7; i++) begin
      iack = iack5[i]; wr = wst5[i]; addr = wst5[i] ? A_STAT : A_COUNT;
      #1;
      chk($sformatf("irq c%0d tc", i), 32'(tc), 32'(tc5[i]));
      chk($sformatf("irq c%0d irq", i), 32'(irq), 32'(irq5[i]));
      step();
    end
    iack = 1'b0; wr = 1'b0;
    wr_reg(A_CTRL, 16'h0);
    iack = 1'b1; step(); iack = 1'b0;
    #1;
    chk("irq after ack", 32'(irq), 32'd0);

    // LIMIT=9: in-run GO=1 write does not disturb the count; RESET at count 4.
    wr_reg(A_LIMIT, 16'h9);
    wr_reg(A_CTRL, 16'h3);
    step(); step();
    wr_reg(A_CTRL, 16'h7);
    rd_chk("mode write count", A_COUNT, 16'h0003);
    step();
    rst = 1'b1;
    rd_chk("pre-reset count", A_COUNT, 16'h0004);
    step();
    rst = 1'b0;
    rd_chk("post-reset count", A_COUNT, 16'h0000);
    chk("post-reset running", 32'(running), 32'd0);
    rd_chk("post-reset ctrl", A_CTRL, 16'h0000);
    rd_chk("post-reset limit", A_LIMIT, 16'hFFFF);

    // LIMIT=0 fires on every tick; RESET suppresses TC in its own cycle.
    wr_reg(A_LIMIT, 16'h0);
    wr_reg(A_CTRL, 16'h3);
    addr = A_COUNT;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("limit0 c%0d tc", i), 32'(tc), 32'd1);
      step();
    end
    rst = 1'b1;
    #1;
    chk("reset tc suppressed", 32'(tc), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("reset running", 32'(running), 32'd0);

    // Full-range one-shot from reset LIMIT=FFFF: TC exactly when count is FFFF.
    wr_reg(A_CTRL, 16'h1);
    addr = A_COUNT; tc_at = -1;
    for (int i = 0; i < 70000; i++) begin
      #1;
      if (tc) begin
        tc_at = i;
        chk("full wrap count at tc", 32'(dout), 32'hFFFF);
        break;
      end
      step();
    end
    chk("full wrap tc cycle", 32'(tc_at), 32'd65535);
    step();
    rd_chk("full wrap count after", A_COUNT, 16'h0000);
    chk("full wrap running", 32'(running), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
